// File: rtl/p_stim_driver_pkg.sv
// Shared types and bus layout for the p_stim_driver harness: FSM states,
// packed iw/ow widths, field positions and the iw packing helper.
package p_stim_driver_pkg;

    typedef enum logic [2:0] {
        INIT_LO,
        INIT_HI,
        IDLE,
        LOW,
        HIGH,
        RESP
    } state_t;

    localparam int unsigned IW_W = 18;
    localparam int unsigned OW_W = 24;

    // iw = {uio_in, ui_in, rst_n, clk}
    localparam int unsigned IW_CLK_BIT  = 0;
    localparam int unsigned IW_RSTN_BIT = 1;
    localparam int unsigned IW_UI_LSB   = 2;
    localparam int unsigned IW_UIO_LSB  = 10;

    // ow = {uio_oe, uio_out, uo_out}
    localparam int unsigned OW_UO_LSB      = 0;
    localparam int unsigned OW_UIO_OUT_LSB = 8;
    localparam int unsigned OW_UIO_OE_LSB  = 16;

    function automatic logic [IW_W-1:0] pack_iw(
        input logic [7:0] uio_in,
        input logic [7:0] ui_in,
        input logic       rst_n,
        input logic       pclk
    );
        logic [IW_W-1:0] w;
        w = '0;
        w[IW_CLK_BIT]       = pclk;
        w[IW_RSTN_BIT]      = rst_n;
        w[IW_UI_LSB +: 8]   = ui_in;
        w[IW_UIO_LSB +: 8]  = uio_in;
        return w;
    endfunction

endpackage

// File: rtl/p_stim_driver_phase_ctr.sv
// Half-period down-counter: reloads on load_i and flags phase_done_o on
// the last system cycle of the current project-clock phase.
module p_stim_phase_ctr #(
    parameter int unsigned HALF_PERIOD = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    output logic phase_done_o
);

    localparam int unsigned CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(HALF_PERIOD - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= RELOAD;
        end else if (load_i) begin
            cnt_q <= RELOAD;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign phase_done_o = (cnt_q == '0);

endmodule

// File: rtl/p_stim_driver.sv
// Harness-side stimulus driver for pNN_wrapper: runs the project reset
// sequence, steps one project clock per command, returns the sampled ow.
// Optional compare/mismatch counting is enabled by P_STIM_DRIVER_COMPARE_EN.
module p_stim_driver
    import p_stim_driver_pkg::*;
#(
    parameter int unsigned HALF_PERIOD  = 2,
    parameter int unsigned RESET_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [15:0]     cmd_data,
    input  logic            cmd_reset,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [23:0]     rsp_data,
    output logic [IW_W-1:0] iw,
    input  logic [OW_W-1:0] ow,
    output logic            ena,
    output logic            busy
`ifdef P_STIM_DRIVER_COMPARE_EN
    ,
    input  logic [23:0]     exp_data,
    input  logic [23:0]     exp_mask,
    output logic            rsp_mismatch,
    output logic [15:0]     mismatch_count
`endif
);

    localparam int unsigned RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RW-1:0] LAST_PERIOD = RW'(RESET_CYCLES - 1);

    state_t       state_q;
    logic         pclk_q;
    logic         rstn_q;
    logic [15:0]  in_q;
    logic         ena_q;
    logic         cmd_ready_q;
    logic         rsp_valid_q;
    logic [23:0]  rsp_data_q;
    logic         busy_q;
    logic [RW-1:0] period_q;

    logic cmd_hs;
    logic rsp_hs;
    logic phase_done;
    logic load_d;

`ifdef P_STIM_DRIVER_COMPARE_EN
    logic [23:0] exp_q;
    logic [23:0] mask_q;
    logic        mismatch_q;
    logic [15:0] mcount_q;
    logic        mismatch_d;
`endif

    always_comb begin
        cmd_hs = cmd_valid & cmd_ready_q;
        rsp_hs = rsp_valid_q & rsp_ready;
        load_d = cmd_hs;
        if (phase_done && (state_q == INIT_LO || state_q == INIT_HI ||
                           state_q == LOW || state_q == HIGH)) begin
            load_d = 1'b1;
        end
    end

`ifdef P_STIM_DRIVER_COMPARE_EN
    always_comb begin
        mismatch_d = |((ow ^ exp_q) & mask_q);
    end
`endif

    p_stim_phase_ctr #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_phase_ctr (
        .clk_i       (clk),
        .rst_i       (rst),
        .load_i      (load_d),
        .phase_done_o(phase_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= INIT_LO;
            pclk_q      <= 1'b0;
            rstn_q      <= 1'b0;
            in_q        <= '0;
            ena_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b1;
            period_q    <= '0;
`ifdef P_STIM_DRIVER_COMPARE_EN
            exp_q       <= '0;
            mask_q      <= '0;
            mismatch_q  <= 1'b0;
            mcount_q    <= '0;
`endif
        end else begin
            case (state_q)
                INIT_LO: begin
                    ena_q <= 1'b1;
                    if (phase_done) begin
                        state_q <= INIT_HI;
                        pclk_q  <= 1'b1;
                    end
                end
                INIT_HI: begin
                    if (phase_done) begin
                        pclk_q <= 1'b0;
                        if (period_q == LAST_PERIOD) begin
                            state_q     <= IDLE;
                            rstn_q      <= 1'b1;
                            cmd_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                        end else begin
                            state_q  <= INIT_LO;
                            period_q <= period_q + 1'b1;
                        end
                    end
                end
                IDLE: begin
                    if (cmd_hs) begin
                        state_q     <= LOW;
                        in_q        <= cmd_data;
                        rstn_q      <= ~cmd_reset;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
`ifdef P_STIM_DRIVER_COMPARE_EN
                        exp_q       <= exp_data;
                        mask_q      <= exp_mask;
`endif
                    end
                end
                LOW: begin
                    if (phase_done) begin
                        state_q <= HIGH;
                        pclk_q  <= 1'b1;
                    end
                end
                HIGH: begin
                    // ow is sampled on the last high cycle, before the falling edge
                    if (phase_done) begin
                        state_q     <= RESP;
                        pclk_q      <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= {ow[OW_UIO_OE_LSB +: 8],
                                        ow[OW_UIO_OUT_LSB +: 8],
                                        ow[OW_UO_LSB +: 8]};
`ifdef P_STIM_DRIVER_COMPARE_EN
                        mismatch_q  <= mismatch_d;
                        if (mismatch_d && (mcount_q != '1)) begin
                            mcount_q <= mcount_q + 1'b1;
                        end
`endif
                    end
                end
                RESP: begin
                    if (rsp_hs) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= INIT_LO;
                end
            endcase
        end
    end

    assign iw        = pack_iw(in_q[15:8], in_q[7:0], rstn_q, pclk_q);
    assign ena       = ena_q;
    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;
`ifdef P_STIM_DRIVER_COMPARE_EN
    assign rsp_mismatch   = mismatch_q;
    assign mismatch_count = mcount_q;
`endif

endmodule

// File: tb/tb_p_stim_driver.sv
// Directed self-checking bench for p_stim_driver with default parameters
// (HALF_PERIOD=2, RESET_CYCLES=4); compare checks need P_STIM_DRIVER_COMPARE_EN.
module tb_p_stim_driver;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_data;
    logic        cmd_reset;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [23:0] rsp_data;
    logic [17:0] iw;
    logic [23:0] ow;
    logic        ena;
    logic        busy;
`ifdef P_STIM_DRIVER_COMPARE_EN
    logic [23:0] exp_data;
    logic [23:0] exp_mask;
    logic        rsp_mismatch;
    logic [15:0] mismatch_count;
`endif

    int errors = 0;
    int checks = 0;

    p_stim_driver #(
        .HALF_PERIOD (2),
        .RESET_CYCLES(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_data (cmd_data),
        .cmd_reset(cmd_reset),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .iw       (iw),
        .ow       (ow),
        .ena      (ena),
        .busy     (busy)
`ifdef P_STIM_DRIVER_COMPARE_EN
        ,
        .exp_data      (exp_data),
        .exp_mask      (exp_mask),
        .rsp_mismatch  (rsp_mismatch),
        .mismatch_count(mismatch_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Waits (bounded) for cmd_ready, then accepts one command; returns in cycle 1.
    task automatic issue(input logic [15:0] data, input logic rs);
        int n;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_timeout: cmd_ready=%b required 1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_data  = data;
        cmd_reset = rs;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Waits (bounded) for rsp_valid and takes the response.
    task automatic collect(output logic [23:0] d);
        int n;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL collect_timeout: rsp_valid=%b required 1", rsp_valid);
        end
        d = rsp_data;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        int rises;
        logic prev_clk;
        rst = 1'b1; cmd_valid = 1'b0; cmd_data = '0; cmd_reset = 1'b0;
        rsp_ready = 1'b0; ow = 24'h123456;
`ifdef P_STIM_DRIVER_COMPARE_EN
        exp_data = '0; exp_mask = '0;
`endif
        repeat (2) @(negedge clk);
        checks++;
        if ({iw, ena, cmd_ready, rsp_valid, rsp_data, busy} !== {18'h0, 1'b0, 1'b0, 1'b0, 24'h0, 1'b1}) begin
            errors++;
            $display("FAIL reset_values: iw=%h ena=%b rdy=%b rv=%b rd=%h busy=%b required 0/0/0/0/0/1",
                     iw, ena, cmd_ready, rsp_valid, rsp_data, busy);
        end
        rst = 1'b0;
        rises = 0;
        prev_clk = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            if (iw[0] && !prev_clk) rises++;
            prev_clk = iw[0];
            checks++;
            if (cmd_ready !== (n == 16) || iw[1] !== (n == 16)) begin
                errors++;
                $display("FAIL init_seq: cycle %0d cmd_ready=%b rst_n=%b required %b", n, cmd_ready, iw[1], n == 16);
            end
        end
        checks++;
        if (rises != 4 || ena !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL init_edges: rises=%0d ena=%b busy=%b required 4/1/0", rises, ena, busy);
        end
    endtask

    task automatic test_basic_step;
        issue(16'h00A5, 1'b0);
        checks++;
        if (iw[9:2] !== 8'hA5 || iw[1] !== 1'b1 || iw[0] !== 1'b0 || cmd_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL step_apply: iw=%h rdy=%b busy=%b required iw=%h rdy=0 busy=1", iw, cmd_ready, busy, 18'h00296);
        end
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== (k == 5) || iw[0] !== (k == 3 || k == 4)) begin
                errors++;
                $display("FAIL step_timing: cycle %0d rsp_valid=%b pclk=%b required %b/%b",
                         k, rsp_valid, iw[0], k == 5, k == 3 || k == 4);
            end
        end
        checks++;
        if (rsp_data !== 24'h123456) begin
            errors++;
            $display("FAIL step_data: rsp_data=%h required 123456", rsp_data);
        end
    endtask

    task automatic test_backpressure;
        ow = 24'hABCDEF;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 24'h123456 || iw[0] !== 1'b0 || cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure: k=%0d rv=%b rd=%h pclk=%b rdy=%b required 1/123456/0/0",
                         k, rsp_valid, rsp_data, iw[0], cmd_ready);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL resp_release: rv=%b rdy=%b busy=%b required 0/1/0", rsp_valid, cmd_ready, busy);
        end
        ow = 24'h123456;
    endtask

    task automatic test_cmd_reset;
        logic [23:0] d;
        ow = 24'h00FF00;
        issue(16'h1234, 1'b1);
        checks++;
        if (iw[1] !== 1'b0 || iw[17:2] !== 16'h1234) begin
            errors++;
            $display("FAIL cmd_reset_on: rst_n=%b in=%h required 0/1234", iw[1], iw[17:2]);
        end
        collect(d);
        checks++;
        if (d !== 24'h00FF00 || iw[1] !== 1'b0) begin
            errors++;
            $display("FAIL cmd_reset_hold: data=%h rst_n=%b required 00ff00/0", d, iw[1]);
        end
        issue(16'hBEEF, 1'b0);
        checks++;
        if (iw[1] !== 1'b1 || iw[17:2] !== 16'hBEEF) begin
            errors++;
            $display("FAIL cmd_reset_off: rst_n=%b in=%h required 1/beef", iw[1], iw[17:2]);
        end
        collect(d);
        ow = 24'h123456;
    endtask

    task automatic test_back_to_back;
        cmd_valid = 1'b1; cmd_data = 16'h0F0F; cmd_reset = 1'b0; rsp_ready = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            checks++;
            if (cmd_ready !== (k % 6 == 0) || rsp_valid !== (k % 6 == 5)) begin
                errors++;
                $display("FAIL back_to_back: cycle %0d rdy=%b rv=%b required %b/%b",
                         k, cmd_ready, rsp_valid, k % 6 == 0, k % 6 == 5);
            end
        end
        cmd_valid = 1'b0; rsp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle: busy=%b rdy=%b required 0/1", busy, cmd_ready);
        end
    endtask

    task automatic test_mid_reset;
        logic [23:0] d;
        issue(16'h5A5A, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (iw[0] !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: pclk=%b required 1", iw[0]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (iw !== 18'h0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0 || busy !== 1'b1 || ena !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: iw=%h rv=%b rdy=%b busy=%b ena=%b required 0/0/0/1/0",
                     iw, rsp_valid, cmd_ready, busy, ena);
        end
        @(negedge clk);
        rst = 1'b0;
        cmd_valid = 1'b1; cmd_data = 16'hC3C3; cmd_reset = 1'b0;
        for (int n = 1; n <= 17; n++) begin
            @(negedge clk);
            if (n == 15) begin
                checks++;
                if (cmd_ready !== 1'b0 || iw[17:1] !== 17'h0) begin
                    errors++;
                    $display("FAIL reinit: rdy=%b iw=%h required 0/0", cmd_ready, iw);
                end
            end
        end
        cmd_valid = 1'b0;
        checks++;
        if (iw[17:2] !== 16'hC3C3 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL reinit_accept: in=%h rdy=%b required c3c3/0", iw[17:2], cmd_ready);
        end
        collect(d);
        checks++;
        if (d !== 24'h123456) begin
            errors++;
            $display("FAIL reinit_data: data=%h required 123456", d);
        end
    endtask

`ifdef P_STIM_DRIVER_COMPARE_EN
    task automatic test_compare;
        logic [23:0] d;
        exp_data = 24'h123457; exp_mask = 24'hFFFFFF;
        issue(16'h0001, 1'b0);
        while (rsp_valid !== 1'b1 && busy === 1'b1) @(negedge clk);
        checks++;
        if (rsp_mismatch !== 1'b1 || mismatch_count !== 16'd1) begin
            errors++;
            $display("FAIL compare_miss: mm=%b cnt=%0d required 1/1", rsp_mismatch, mismatch_count);
        end
        collect(d);
        exp_mask = 24'hFFFFFE;
        issue(16'h0002, 1'b0);
        while (rsp_valid !== 1'b1 && busy === 1'b1) @(negedge clk);
        checks++;
        if (rsp_mismatch !== 1'b0 || mismatch_count !== 16'd1) begin
            errors++;
            $display("FAIL compare_masked: mm=%b cnt=%0d required 0/1", rsp_mismatch, mismatch_count);
        end
        collect(d);
    endtask
`endif

    initial begin
        test_reset();
        test_basic_step();
        test_backpressure();
        test_cmd_reset();
        test_back_to_back();
        test_mid_reset();
`ifdef P_STIM_DRIVER_COMPARE_EN
        test_compare();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
